// File: rtl/step_pkg.sv
// Shared definitions for the step-pulse generator and receiver: state encoding
// and default sizing.
package step_pkg;

    localparam int STEP_SIZE    = 16;
    localparam int STEP_POS_W   = 32;
    localparam int STEP_TIMEOUT = 4000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } step_state_t;

endpackage

// File: rtl/step_sync_edge.sv
// Brings the asynchronous step/dir lines into the clk domain and produces
// registered one-cycle rise/fall strobes plus the direction captured with them.
module step_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic step_in,
    input  logic dir_in,
    input  logic invert_pulse,
    output logic rise,
    output logic fall,
    output logic dir
);

    logic [1:0] step_sync;
    logic [1:0] dir_sync;
    logic       step_lvl;
    logic       step_prev;

    assign step_lvl = step_sync[1] ^ invert_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_sync <= 2'b00;
            dir_sync  <= 2'b00;
            // Matches the level seen straight out of reset, so an idle-high
            // active-low line does not produce a phantom rise.
            step_prev <= invert_pulse;
            rise      <= 1'b0;
            fall      <= 1'b0;
            dir       <= 1'b0;
        end else begin
            step_sync <= {step_sync[0], step_in};
            dir_sync  <= {dir_sync[0], dir_in};
            step_prev <= step_lvl;
            rise      <= step_lvl & ~step_prev;
            fall      <= ~step_lvl & step_prev;
            dir       <= dir_sync[1];
        end
    end

endmodule

// File: rtl/step_pulse_rx.sv
// Step-interface receive monitor: counts synchronised step pulses into a signed
// position and a per-run count, measures period/high width, flags done and stall.
module step_pulse_rx
    import step_pkg::*;
#(
    parameter int SIZE    = STEP_SIZE,
    parameter int POS_W   = STEP_POS_W,
    parameter int TIMEOUT = STEP_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_in,
    input  logic                    dir_in,
    input  logic                    invert_pulse,
    input  logic                    en,
    input  logic                    clr_pos,
    input  logic [SIZE-1:0]         target,
    output logic [SIZE-1:0]         period,
    output logic [SIZE-1:0]         width,
    output logic                    meas_v,
    output logic signed [POS_W-1:0] position,
    output logic [SIZE-1:0]         pulse_cnt,
    output logic                    done,
    output logic                    stall,
    output step_state_t             state
);

    localparam logic [SIZE-1:0]         CNT_MAX    = {SIZE{1'b1}};
    localparam logic [SIZE-1:0]         CNT_ONE    = SIZE'(1);
    localparam logic [SIZE-1:0]         TIMEOUT_M1 = SIZE'(TIMEOUT - 1);
    localparam logic signed [POS_W-1:0] POS_ONE    = POS_W'(1);

    step_state_t     state_next;
    logic            rise;
    logic            fall;
    logic            dir;
    logic            count_rise;
    logic [SIZE-1:0] timer;
    logic [SIZE-1:0] high_timer;

    function automatic logic [SIZE-1:0] sat_inc(input logic [SIZE-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    step_sync_edge u_sync (
        .clk          (clk),
        .rst          (rst),
        .step_in      (step_in),
        .dir_in       (dir_in),
        .invert_pulse (invert_pulse),
        .rise         (rise),
        .fall         (fall),
        .dir          (dir)
    );

    // A rise is only counted once the monitor has been armed and is still enabled.
    assign count_rise = en && rise && (state != IDLE);
    assign stall      = (state == STALL);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = ARMED;
            ARMED:   if (rise) state_next = RUN;
            RUN:     if (!rise && timer == TIMEOUT_M1) state_next = STALL;
            STALL:   if (rise) state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!en) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            period     <= '0;
            width      <= '0;
            meas_v     <= 1'b0;
            position   <= '0;
            pulse_cnt  <= '0;
            done       <= 1'b0;
            timer      <= '0;
            high_timer <= '0;
        end else begin
            state  <= state_next;
            meas_v <= 1'b0;
            done   <= (state_next != IDLE) && (target != '0) && (pulse_cnt >= target);

            if (clr_pos) begin
                position <= '0;
            end else if (count_rise) begin
                position <= dir ? position + POS_ONE : position - POS_ONE;
            end

            if (state_next == IDLE) begin
                pulse_cnt  <= '0;
                timer      <= '0;
                high_timer <= '0;
            end else begin
                case (state)
                    ARMED: begin
                        if (rise) begin
                            pulse_cnt  <= CNT_ONE;
                            timer      <= '0;
                            high_timer <= '0;
                        end
                    end
                    RUN, STALL: begin
                        if (rise) begin
                            timer      <= '0;
                            high_timer <= '0;
                            pulse_cnt  <= sat_inc(pulse_cnt);
                            // The interval that ended in a stall is not a valid period.
                            if (state == RUN) begin
                                period <= sat_inc(timer);
                                meas_v <= 1'b1;
                            end
                        end else begin
                            timer      <= sat_inc(timer);
                            high_timer <= sat_inc(high_timer);
                        end
                        if (fall && state == RUN) begin
                            width <= sat_inc(high_timer);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_step_pulse_rx.sv
// Directed bench for step_pulse_rx: a full-size instance and a narrow instance
// (8-bit counters, 4-bit position, TIMEOUT 255) for saturation/wrap/stall edges.
module tb_step_pulse_rx;
    import step_pkg::*;

    // Handshake: meas_v is a one-cycle valid with no ready; every strobe must
    // match the head of the expected-period queue for that instance.

    logic clk;
    logic rst;
    logic dir;
    logic step_a, inv_a, en_a, clr_a;
    logic [15:0] target_a;
    logic [15:0] period_a, width_a, pulse_cnt_a;
    logic meas_v_a, done_a, stall_a;
    logic signed [31:0] position_a;
    step_state_t state_a;

    logic step_b, en_b;
    logic [7:0] target_b;
    logic [7:0] period_b, width_b, pulse_cnt_b;
    logic meas_v_b, done_b, stall_b;
    logic signed [3:0] position_b;
    step_state_t state_b;

    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int cnt_cyc_a = 0, done_cyc_a = 0, stall_cyc_a = 0;
    logic [15:0] cnt_prev_a = '0;
    logic done_prev_a = 1'b0, stall_prev_a = 1'b0;

    step_pulse_rx u_dut_a (
        .clk(clk), .rst(rst), .step_in(step_a), .dir_in(dir), .invert_pulse(inv_a),
        .en(en_a), .clr_pos(clr_a), .target(target_a), .period(period_a),
        .width(width_a), .meas_v(meas_v_a), .position(position_a),
        .pulse_cnt(pulse_cnt_a), .done(done_a), .stall(stall_a), .state(state_a)
    );

    step_pulse_rx #(.SIZE(8), .POS_W(4), .TIMEOUT(255)) u_dut_b (
        .clk(clk), .rst(rst), .step_in(step_b), .dir_in(dir), .invert_pulse(1'b0),
        .en(en_b), .clr_pos(1'b0), .target(target_b), .period(period_b),
        .width(width_b), .meas_v(meas_v_b), .position(position_b),
        .pulse_cnt(pulse_cnt_b), .done(done_b), .stall(stall_b), .state(state_b)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (!rst && meas_v_a) begin
            if (exp_q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL meas_a_unexpected: period %0d, expected no strobe", period_a);
            end else begin
                check("meas_a_period", period_a, exp_q_a.pop_front());
            end
        end
        if (!rst && meas_v_b) begin
            if (exp_q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL meas_b_unexpected: period %0d, expected no strobe", period_b);
            end else begin
                check("meas_b_period", {8'd0, period_b}, exp_q_b.pop_front());
            end
        end
    end

    // Event timestamps for latency checks
    always @(negedge clk) begin
        if (pulse_cnt_a != cnt_prev_a && pulse_cnt_a != 0) cnt_cyc_a = cyc;
        cnt_prev_a = pulse_cnt_a;
        if (done_a && !done_prev_a) done_cyc_a = cyc;
        done_prev_a = done_a;
        if (stall_a && !stall_prev_a) stall_cyc_a = cyc;
        stall_prev_a = stall_a;
    end

    // Driver tasks
    task automatic set_step(input int sel, input logic lvl);
        if (sel == 0) step_a = lvl ^ inv_a;
        else step_b = lvl;
    endtask

    task automatic pulse(input int sel, input int high, input int per);
        set_step(sel, 1'b1);
        repeat (high) @(negedge clk);
        set_step(sel, 1'b0);
        repeat (per - high) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; dir = 1'b1;
        step_a = 1'b0; inv_a = 1'b0; en_a = 1'b0; clr_a = 1'b0; target_a = 16'd5;
        step_b = 1'b0; en_b = 1'b0; target_b = 8'd0;
        repeat (3) @(negedge clk);

        check("rst_period", period_a, 0);
        check("rst_width", width_a, 0);
        check("rst_meas_v", meas_v_a, 0);
        check("rst_position", position_a, 0);
        check("rst_pulse_cnt", pulse_cnt_a, 0);
        check("rst_done", done_a, 0);
        check("rst_stall", stall_a, 0);
        check("rst_state", state_a, IDLE);
        rst = 1'b0;
        @(negedge clk);

        // Five up pulses, period 2000, high 500, target 5
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) exp_q_a.push_back(16'd2000);
            pulse(0, 500, 2000);
        end
        check("t1_position", position_a, 5);
        check("t1_pulse_cnt", pulse_cnt_a, 5);
        check("t1_period", period_a, 2000);
        check("t1_width", width_a, 500);
        check("t1_done", done_a, 1);
        check("t1_done_latency", done_cyc_a - cnt_cyc_a, 1);
        check("t1_strobes_left", exp_q_a.size(), 0);

        // Three down pulses, then clr_pos on the rise cycle
        dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q_a.push_back(16'd2000);
            pulse(0, 500, 2000);
        end
        check("t2_position_down", position_a, 2);
        check("t2_pulse_cnt", pulse_cnt_a, 8);
        exp_q_a.push_back(16'd2000);
        set_step(0, 1'b1);
        repeat (3) @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        repeat (496) @(negedge clk);
        set_step(0, 1'b0);
        repeat (1500) @(negedge clk);
        check("t2_position_clr", position_a, 0);
        check("t2_pulse_cnt_clr", pulse_cnt_a, 9);

        // Active-low pulses: low 100, period 400
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_idle_state", state_a, IDLE);
        check("t3_idle_pulse_cnt", pulse_cnt_a, 0);
        check("t3_idle_done", done_a, 0);
        inv_a = 1'b1;
        set_step(0, 1'b0);
        dir = 1'b1;
        target_a = 16'd0;
        repeat (5) @(negedge clk);
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) exp_q_a.push_back(16'd400);
            pulse(0, 100, 400);
        end
        check("t3_width", width_a, 100);
        check("t3_period", period_a, 400);
        check("t3_position", position_a, 3);

        // Stall after TIMEOUT cycles, recovery without a strobe
        n = 0;
        while (!stall_a && n < 5000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("t4_stall_seen", stall_a, 1);
        check("t4_stall_delay", stall_cyc_a - cnt_cyc_a, 4000);
        pulse(0, 100, 400);
        check("t4_stall_cleared", stall_a, 0);
        check("t4_pulse_cnt", pulse_cnt_a, 4);
        check("t4_period_held", period_a, 400);
        exp_q_a.push_back(16'd400);
        pulse(0, 100, 400);
        check("t4_pulse_cnt2", pulse_cnt_a, 5);
        check("t4_done_target0", done_a, 0);
        check("t4_strobes_left", exp_q_a.size(), 0);

        // en dropped on the rise cycle: rise ignored, position held
        set_step(0, 1'b1);
        repeat (3) @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        check("t5_en_state", state_a, IDLE);
        check("t5_en_pulse_cnt", pulse_cnt_a, 0);
        check("t5_en_position", position_a, 5);
        repeat (96) @(negedge clk);
        set_step(0, 1'b0);
        repeat (300) @(negedge clk);

        // Reset mid-run
        target_a = 16'd2;
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) exp_q_a.push_back(16'd400);
            pulse(0, 100, 400);
        end
        check("t6_done", done_a, 1);
        check("t6_position", position_a, 8);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_state", state_a, IDLE);
        check("t6_rst_pulse_cnt", pulse_cnt_a, 0);
        check("t6_rst_done", done_a, 0);
        check("t6_rst_position", position_a, 0);
        rst = 1'b0;
        en_a = 1'b0;
        repeat (3) @(negedge clk);

        // Narrow instance: period 254 measured, 300-cycle gap stalls
        en_b = 1'b1;
        dir = 1'b1;
        repeat (2) @(negedge clk);
        pulse(1, 50, 254);
        exp_q_b.push_back(16'd254);
        pulse(1, 50, 300);
        check("b_period_below_timeout", period_b, 254);
        check("b_stall", stall_b, 1);
        pulse(1, 2, 4);
        check("b_stall_cleared", stall_b, 0);
        check("b_period_held", period_b, 254);
        check("b_position3", position_b, 3);
        for (int i = 0; i < 5; i++) begin
            exp_q_b.push_back(16'd4);
            pulse(1, 2, 4);
        end
        check("b_position_wrap", position_b, -8);
        for (int i = 0; i < 252; i++) begin
            exp_q_b.push_back(16'd4);
            pulse(1, 2, 4);
        end
        check("b_pulse_cnt_sat", pulse_cnt_b, 255);
        check("b_position_260", position_b, 4);
        check("b_period_fast", period_b, 4);
        check("b_width_fast", width_b, 2);
        check("b_done_target0", done_b, 0);
        repeat (4) @(negedge clk);
        check("a_strobes_left", exp_q_a.size(), 0);
        check("b_strobes_left", exp_q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_pulse_rx.md
# step_pulse_rx

Receive-side monitor for the stepper-motor step interface. It takes a step line and direction line from an external or looped-back source, synchronises them, and counts step pulses into a signed position and a per-run pulse count. It also measures step period and high width, and flags completion of a target count and stalls. It sits beside the step-pulse generator: the controller uses it for closed-loop checks on generated pulses and for monitoring external step sources.

## Interface
Parameters:
- SIZE, 16: width of period, width, pulse count and target.
- POS_W, 32: width of the signed position counter.
- TIMEOUT, 4000: clk cycles without a rising edge before RUN enters STALL. Must be at least 2 and at most 2^SIZE-1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, synchronous, active-high; one clock, `clk`.
- step_in  in  1  asynchronous step line.
- dir_in  in  1  asynchronous direction line: 1 counts up, 0 counts down.
- invert_pulse  in  1  1: step_in is active-low and is inverted after synchronisation.
- en  in  1  monitoring enable.
- clr_pos  in  1  synchronous clear of position.
- target  in  SIZE  pulse count for done; 0 disables done.
- period  out  SIZE  last rise-to-rise interval in clk cycles; saturates at 2^SIZE-1.
- width  out  SIZE  last high time in clk cycles; saturates.
- meas_v  out  1  one-cycle strobe when period is updated.
- position  out  POS_W  signed step position; wraps in two's complement.
- pulse_cnt  out  SIZE  rising edges counted since leaving IDLE; saturates.
- done  out  1  level output.
- stall  out  1  level output; high in STALL.

## Operation
- step_in and dir_in each pass through a 2-FF synchroniser. invert_pulse is XORed after sync. rise and fall are detected against a third register.
- dir is sampled from the synchronised dir on the rise cycle.
- States:
  - IDLE: entered on reset or whenever en=0, from any state, on the next edge. Clears pulse_cnt, done, stall and timers. Holds position, period and width.
  - ARMED: entered from IDLE when en=1. Waits for the first rise. On rise: pulse_cnt=1, position ±1, timers=0, go to RUN. No meas_v.
  - RUN: the period timer increments each cycle and saturates.
    - On rise: period <= timer+1 (saturating), meas_v=1, timer=0, pulse_cnt+1, position ±1.
    - On fall: width <= high timer+1. The high timer is reset on rise.
    - When timer reaches TIMEOUT-1 with no rise: go to STALL.
  - STALL: stall=1. On rise: go to RUN, count the pulse, timer=0, stall=0. Period is not updated and meas_v stays low.
- done is registered: done = (target≠0) && (pulse_cnt ≥ target). It is evaluated continuously, so a target change takes effect on the next cycle.
- Boundary rules:
  - clr_pos on the same cycle as a rise: position=0; the pulse still counts in pulse_cnt.
  - en falling on a rise cycle: the rise is ignored.
  - pulse_cnt stops at 2^SIZE-1.
  - position wraps from +max to -min.

## Timing
- Reset values: period=0, width=0, meas_v=0, position=0, pulse_cnt=0, done=0, stall=0. State is IDLE.
- Latency: step_in first sampled high at edge k. The rise is detected at edge k+2. pulse_cnt, position, period and meas_v update at edge k+3.
- done follows pulse_cnt by 1 cycle.
- stall asserts TIMEOUT cycles after the last rise.
- meas_v lasts exactly 1 cycle. Rises 2 cycles apart are the minimum resolvable.
- Pulses shorter than 1 clk may be missed. No glitch filter is provided.

## Structure
- Package step_pkg holds the state enum (IDLE, ARMED, RUN, STALL) and the default SIZE and TIMEOUT, shared with the generator.
- Sub-module step_sync_edge contains the 2-FF synchronisers, the invert XOR, the third register, and the rise/fall/dir outputs.
- The top level contains the FSM, timers and counters.

## Test plan
- en=1, target=5, 5 pulses with period 2000 cycles and high time 500, dir=1 → position=5, pulse_cnt=5, period=2000, width=500, 4 meas_v strobes, done=1 one cycle after the 5th count.
- dir=0, 3 pulses from position 5 → position=2. Then clr_pos coincident with a rise → position=0, pulse_cnt incremented.
- invert_pulse=1, active-low pulses with low time 100 and period 400 → width=100, period=400.
- Stop pulses in RUN with TIMEOUT=4000 → stall=1 4000 cycles after the last rise. The next rise clears stall with no meas_v; the following rise gives meas_v with the correct period.
- Period 70000 cycles with TIMEOUT raised to 65535 and SIZE=16 → stall asserts. With a period just below TIMEOUT, period equals that value.
- en dropped mid-run, then rst mid-run → IDLE next edge, pulse_cnt=0, done=0. Position is held after en drop and cleared after rst.
